height_capture_multi: RTL and testbench

- Parametrised successor to the single-channel height latch FSM. Sits between the height calculator and the display/UART readout.
- Takes a live height each cycle and detects a person using enter/exit hysteresis thresholds.
- Requires presence for HOLD_TICKS, then captures either the peak or the final height, with a debounced exit.
- Stores captures in a circular history of depth HIST_DEPTH, with an indexed read port, a clear input and a save LED pulse.

---
 rtl/height_capture_multi.sv | 193 +++++++++++++++++++
 tb/tb_height_capture_multi.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/height_capture_multi.sv
// Presence-triggered height capture with enter/exit hysteresis, timed hold,
// debounced exit and a circular capture history with indexed readback.
module height_capture_multi #(
    parameter int W           = 8,
    parameter int HIST_DEPTH  = 10,
    parameter int ENTER_TH    = 36,
    parameter int EXIT_TH     = 32,
    parameter int HOLD_TICKS  = 36_000_000,
    parameter int EXIT_TICKS  = 1_200_000,
    parameter int FLASH_TICKS = 3_000_000
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [W-1:0]                    height_in,
    input  logic                            mode_max,
    input  logic                            clear_hist,
    input  logic [$clog2(HIST_DEPTH)-1:0]   rd_idx,
    output logic [W-1:0]                    rd_data,
    output logic [$clog2(HIST_DEPTH+1)-1:0] hist_count,
    output logic [W-1:0]                    latched_height,
    output logic [W-1:0]                    display_height,
    output logic [1:0]                      state_out,
    output logic                            save_pulse,
    output logic                            led_save
);
    localparam int IW = $clog2(HIST_DEPTH);
    localparam int CW = $clog2(HIST_DEPTH + 1);
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam int EW = $clog2(EXIT_TICKS + 1);
    localparam int FW = (FLASH_TICKS < 1) ? 1 : $clog2(FLASH_TICKS + 1);

    localparam logic [W-1:0]  ENTER_V  = W'(ENTER_TH);
    localparam logic [W-1:0]  EXIT_V   = W'(EXIT_TH);
    localparam logic [HW-1:0] HOLD_V   = HW'(HOLD_TICKS);
    localparam logic [EW-1:0] EXIT_LST = EW'(EXIT_TICKS - 1);
    localparam logic [FW-1:0] FLASH_V  = FW'(FLASH_TICKS);
    localparam logic [IW-1:0] LAST_PTR = IW'(HIST_DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(HIST_DEPTH);
    localparam logic [IW:0]   DEPTH_M1 = (IW+1)'(HIST_DEPTH - 1);
    localparam logic [IW:0]   DEPTH_V  = (IW+1)'(HIST_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_TIMING  = 2'd1,
        S_LATCHED = 2'd2
    } state_t;

    state_t        r_state, w_state_n;
    logic [HW-1:0] r_hold_cnt, w_hold_n;
    logic [EW-1:0] r_exit_cnt, w_exit_n;
    logic [W-1:0]  r_peak, w_peak_n;
    logic          r_mode, w_mode_n;
    logic [W-1:0]  r_latched, w_latched_n;
    logic          w_capture;
    logic          r_save_pulse;
    logic [FW-1:0] r_flash_cnt;

    logic          w_present, w_absent;
    logic [W-1:0]  w_max;

    assign w_present = (height_in >= ENTER_V);
    assign w_absent  = (height_in < EXIT_V);
    assign w_max     = (height_in > r_peak) ? height_in : r_peak;

    always_comb begin
        w_state_n   = r_state;
        w_hold_n    = r_hold_cnt;
        w_exit_n    = r_exit_cnt;
        w_peak_n    = r_peak;
        w_mode_n    = r_mode;
        w_latched_n = r_latched;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_present) begin
                    w_state_n = S_TIMING;
                    w_hold_n  = HW'(1);
                    w_peak_n  = height_in;
                    w_mode_n  = mode_max;
                end
            end
            S_TIMING: begin
                if (w_absent) begin
                    w_state_n = S_IDLE;
                    w_hold_n  = '0;
                end else if (r_hold_cnt == HOLD_V) begin
                    w_state_n   = S_LATCHED;
                    w_hold_n    = '0;
                    w_exit_n    = '0;
                    w_peak_n    = w_max;
                    w_latched_n = r_mode ? w_max : height_in;
                    w_capture   = 1'b1;
                end else begin
                    w_hold_n = r_hold_cnt + HW'(1);
                    w_peak_n = w_max;
                end
            end
            S_LATCHED: begin
                // Any present sample restarts the debounce window.
                if (!w_absent) begin
                    w_exit_n = '0;
                end else if (r_exit_cnt == EXIT_LST) begin
                    w_state_n = S_IDLE;
                    w_exit_n  = '0;
                end else begin
                    w_exit_n = r_exit_cnt + EW'(1);
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_hold_n  = '0;
                w_exit_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_hold_cnt   <= '0;
            r_exit_cnt   <= '0;
            r_peak       <= '0;
            r_mode       <= 1'b0;
            r_latched    <= '0;
            r_save_pulse <= 1'b0;
            r_flash_cnt  <= '0;
        end else begin
            r_state      <= w_state_n;
            r_hold_cnt   <= w_hold_n;
            r_exit_cnt   <= w_exit_n;
            r_peak       <= w_peak_n;
            r_mode       <= w_mode_n;
            r_latched    <= w_latched_n;
            r_save_pulse <= w_capture;
            if (w_capture)
                r_flash_cnt <= FLASH_V;
            else if (r_flash_cnt != '0)
                r_flash_cnt <= r_flash_cnt - FW'(1);
        end
    end

    logic [W-1:0]  r_hist [HIST_DEPTH];
    logic [IW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [IW-1:0] w_base, w_ptr_n;

    // A clear coinciding with a save restarts the ring so the new entry lands at slot 0.
    assign w_base  = clear_hist ? '0 : r_wr_ptr;
    assign w_ptr_n = (w_base == LAST_PTR) ? '0 : w_base + IW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) r_hist[i] <= '0;
        end else if (r_save_pulse) begin
            r_hist[w_base] <= r_latched;
            r_wr_ptr       <= w_ptr_n;
            if (clear_hist)
                r_count <= CW'(1);
            else if (r_count != FULL_CNT)
                r_count <= r_count + CW'(1);
        end else if (clear_hist) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
        end
    end

    logic          w_rd_valid;
    logic [IW:0]   w_sum, w_slot;
    logic [IW-1:0] w_idx;

    assign w_rd_valid = (CW'(rd_idx) < r_count);

    always_comb begin
        w_sum   = {1'b0, r_wr_ptr} + DEPTH_M1 - {1'b0, rd_idx};
        w_slot  = (w_sum >= DEPTH_V) ? (w_sum - DEPTH_V) : w_sum;
        w_idx   = '0;
        rd_data = '0;
        if (w_rd_valid) begin
            w_idx   = w_slot[IW-1:0];
            rd_data = r_hist[w_idx];
        end
    end

    assign hist_count     = r_count;
    assign latched_height = r_latched;
    assign display_height = (r_state == S_LATCHED) ? r_latched : height_in;
    assign state_out      = r_state;
    assign save_pulse     = r_save_pulse;
    assign led_save       = (r_flash_cnt != '0);

endmodule

// File: tb/tb_height_capture_multi.sv
// Scenario bench for height_capture_multi; expectations come from a queue-based
// history model and max/last-sample rules applied to each presence window.
module tb_height_capture_multi;
    localparam int W = 8, DEPTH = 4, ENTER = 36, EXIT = 32;
    localparam int HOLD = 8, EXITT = 3, FLASH = 4;

    logic       clk = 0, reset_n = 0;
    logic [7:0] height_in = 0;
    logic       mode_max = 0, clear_hist = 0;
    logic [1:0] rd_idx = 0;
    logic [7:0] rd_data, latched_height, display_height;
    logic [2:0] hist_count;
    logic [1:0] state_out;
    logic       save_pulse, led_save;

    height_capture_multi #(.W(W), .HIST_DEPTH(DEPTH), .ENTER_TH(ENTER), .EXIT_TH(EXIT),
        .HOLD_TICKS(HOLD), .EXIT_TICKS(EXITT), .FLASH_TICKS(FLASH)) dut (
        .clk(clk), .reset_n(reset_n), .height_in(height_in), .mode_max(mode_max),
        .clear_hist(clear_hist), .rd_idx(rd_idx), .rd_data(rd_data), .hist_count(hist_count),
        .latched_height(latched_height), .display_height(display_height),
        .state_out(state_out), .save_pulse(save_pulse), .led_save(led_save));

    always #5 clk = ~clk;

    int         checks = 0, passes = 0;
    logic [7:0] hq[$];
    logic [7:0] seq [0:HOLD];
    logic [7:0] last_latched = 0;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic run_capture(input bit mode, input bit clr, input bit do_exit);
        logic [7:0] mx, exp, want;
        int leds;
        mx = 0;
        for (int i = 0; i <= HOLD; i++) begin
            height_in = seq[i]; mode_max = (i == 0) ? mode : !mode; #1;
            if (seq[i] > mx) mx = seq[i];
            checks++; if (state_out !== ((i == 0) ? 2'd0 : 2'd1)) $display("FAIL timing_state[%0d]: got %0d want %0d", i, state_out, (i == 0) ? 0 : 1); else passes++;
            checks++; if (save_pulse !== 1'b0) $display("FAIL early_save[%0d]: got %0d want 0", i, save_pulse); else passes++;
            tick();
        end
        exp = mode ? mx : seq[HOLD];
        height_in = 8'($urandom_range(EXIT, 120)); clear_hist = clr; #1;
        checks++; if (state_out !== 2'd2) $display("FAIL latched_state: got %0d want 2", state_out); else passes++;
        checks++; if (save_pulse !== 1'b1) $display("FAIL save_pulse: got %0d want 1", save_pulse); else passes++;
        checks++; if (latched_height !== exp) $display("FAIL latched_height: got %0d want %0d", latched_height, exp); else passes++;
        checks++; if (display_height !== exp) $display("FAIL display_latched: got %0d want %0d", display_height, exp); else passes++;
        leds = int'(led_save);
        tick(); clear_hist = 0;
        last_latched = exp;
        if (clr) hq.delete();
        hq.push_front(exp);
        if (hq.size() > DEPTH) void'(hq.pop_back());
        checks++; if (save_pulse !== 1'b0) $display("FAIL save_once: got %0d want 0", save_pulse); else passes++;
        checks++; if (int'(hist_count) !== hq.size()) $display("FAIL hist_count: got %0d want %0d", hist_count, hq.size()); else passes++;
        for (int k = 0; k < DEPTH; k++) begin
            rd_idx = 2'(k); #1;
            want = (k < hq.size()) ? hq[k] : 8'd0;
            checks++; if (rd_data !== want) $display("FAIL rd_data[%0d]: got %0d want %0d", k, rd_data, want); else passes++;
        end
        if (!do_exit) return;
        for (int j = 0; j < EXITT; j++) begin
            height_in = 8'($urandom_range(0, EXIT - 1)); #1;
            checks++; if (state_out !== 2'd2 || display_height !== exp) $display("FAIL exit_hold[%0d]: got %0d/%0d want 2/%0d", j, state_out, display_height, exp); else passes++;
            leds += int'(led_save);
            tick();
        end
        for (int j = 0; j < 2; j++) begin
            height_in = 8'($urandom_range(0, EXIT - 1)); #1;
            if (j == 0) begin
                checks++; if (state_out !== 2'd0) $display("FAIL exit_idle: got %0d want 0", state_out); else passes++;
            end
            leds += int'(led_save);
            tick();
        end
        checks++; if (leds != FLASH) $display("FAIL led_cycles: got %0d want %0d", leds, FLASH); else passes++;
    endtask

    task automatic test_reset();
        reset_n = 0; height_in = 8'd77;
        repeat (2) tick();
        checks++; if (state_out !== 2'd0) $display("FAIL reset_state: got %0d want 0", state_out); else passes++;
        checks++; if (hist_count !== 3'd0 || rd_data !== 8'd0) $display("FAIL reset_hist: got %0d/%0d want 0/0", hist_count, rd_data); else passes++;
        checks++; if (save_pulse !== 1'b0 || led_save !== 1'b0) $display("FAIL reset_flags: got %0d/%0d want 0/0", save_pulse, led_save); else passes++;
        checks++; if (latched_height !== 8'd0) $display("FAIL reset_latched: got %0d want 0", latched_height); else passes++;
        checks++; if (display_height !== 8'd77) $display("FAIL reset_display: got %0d want 77", display_height); else passes++;
        height_in = 0; reset_n = 1; tick();
    endtask

    task automatic test_peak();
        seq[0] = 40; seq[1] = 50;
        for (int i = 2; i <= HOLD; i++) seq[i] = 45;
        run_capture(1'b1, 1'b0, 1'b1);
        checks++; if (latched_height !== 8'd50) $display("FAIL peak_value: got %0d want 50", latched_height); else passes++;
    endtask

    task automatic test_last();
        for (int i = 0; i < HOLD; i++) seq[i] = 50;
        seq[HOLD] = 41;
        run_capture(1'b0, 1'b0, 1'b1);
        checks++; if (latched_height !== 8'd41) $display("FAIL last_value: got %0d want 41", latched_height); else passes++;
    endtask

    task automatic test_abort();
        height_in = 40;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (state_out !== ((i == 0) ? 2'd0 : 2'd1)) $display("FAIL abort_timing[%0d]: got %0d", i, state_out); else passes++;
            tick();
        end
        height_in = 30;
        for (int i = 0; i < HOLD + 2; i++) begin
            tick();
            checks++; if (state_out !== 2'd0 || save_pulse !== 1'b0) $display("FAIL abort_idle[%0d]: got %0d/%0d want 0/0", i, state_out, save_pulse); else passes++;
        end
        checks++; if (latched_height !== last_latched) $display("FAIL abort_latched: got %0d want %0d", latched_height, last_latched); else passes++;
        height_in = 34;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (state_out !== 2'd0) $display("FAIL band_idle[%0d]: got %0d want 0", i, state_out); else passes++;
        end
        seq[0] = 38;
        for (int i = 1; i <= HOLD; i++) seq[i] = (i % 2 == 1) ? 8'd34 : 8'(37 + i);
        run_capture(1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_exit();
        logic [7:0] pat [6] = '{20, 20, 40, 20, 20, 20};
        for (int i = 0; i <= HOLD; i++) seq[i] = 8'(55 + i);
        run_capture(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            height_in = pat[i]; #1;
            checks++; if (state_out !== 2'd2 || display_height !== last_latched) $display("FAIL debounce[%0d]: got %0d/%0d want 2/%0d", i, state_out, display_height, last_latched); else passes++;
            tick();
        end
        checks++; if (state_out !== 2'd0 || display_height !== 8'd20) $display("FAIL debounce_exit: got %0d/%0d want 0/20", state_out, display_height); else passes++;
        repeat (FLASH) tick();
    endtask

    task automatic test_random();
        bit m, c;
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i <= HOLD; i++)
                seq[i] = (i > 0 && $urandom_range(0, 3) == 0) ? 8'($urandom_range(EXIT, ENTER - 1))
                                                              : 8'($urandom_range(ENTER, 200));
            m = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 3) == 0);
            run_capture(m, c, 1'b1);
        end
    endtask

    task automatic test_wrap();
        clear_hist = 1; tick(); clear_hist = 0; hq.delete();
        rd_idx = 0; #1;
        checks++; if (hist_count !== 3'd0 || rd_data !== 8'd0) $display("FAIL clear_empty: got %0d/%0d want 0/0", hist_count, rd_data); else passes++;
        rd_idx = 3; #1;
        checks++; if (rd_data !== 8'd0) $display("FAIL empty_rd3: got %0d want 0", rd_data); else passes++;
        for (int v = 40; v <= 44; v++) begin
            for (int i = 0; i <= HOLD; i++) seq[i] = 8'(v);
            run_capture(1'($urandom_range(0, 1)), 1'b0, 1'b1);
        end
        checks++; if (hist_count !== 3'd4) $display("FAIL wrap_count: got %0d want 4", hist_count); else passes++;
        for (int k = 0; k < DEPTH; k++) begin
            rd_idx = 2'(k); #1;
            checks++; if (rd_data !== 8'(44 - k)) $display("FAIL wrap_rd[%0d]: got %0d want %0d", k, rd_data, 44 - k); else passes++;
        end
    endtask

    task automatic test_clear_save();
        for (int i = 0; i <= HOLD; i++) seq[i] = 45;
        run_capture(1'b1, 1'b1, 1'b1);
        rd_idx = 0; #1;
        checks++; if (hist_count !== 3'd1 || rd_data !== 8'd45) $display("FAIL clear_save: got %0d/%0d want 1/45", hist_count, rd_data); else passes++;
    endtask

    task automatic test_reset_mid();
        height_in = 50; mode_max = 1;
        repeat (4) tick();
        checks++; if (state_out !== 2'd1) $display("FAIL pre_reset_timing: got %0d want 1", state_out); else passes++;
        reset_n = 0; #1;
        checks++; if (state_out !== 2'd0 || hist_count !== 3'd0) $display("FAIL mid_reset: got %0d/%0d want 0/0", state_out, hist_count); else passes++;
        checks++; if (save_pulse !== 1'b0 || led_save !== 1'b0 || latched_height !== 8'd0) $display("FAIL mid_reset_out: got %0d/%0d/%0d want 0/0/0", save_pulse, led_save, latched_height); else passes++;
        height_in = 0; tick(); reset_n = 1; hq.delete();
        for (int i = 0; i < HOLD + 4; i++) begin
            tick();
            checks++; if (save_pulse !== 1'b0 || state_out !== 2'd0) $display("FAIL post_reset[%0d]: got %0d/%0d want 0/0", i, save_pulse, state_out); else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_peak();
        test_last();
        test_abort();
        test_exit();
        test_random();
        test_wrap();
        test_clear_save();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
